// File: rtl/st_addr_match_queue_if.sv
// Push/pop/lookup bundle for st_addr_match_queue; the master drives requests, the slave is the queue.
interface st_addr_match_queue_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
);
  localparam int PW = $clog2(DEPTH);

  logic          flush;
  logic          push_valid;
  logic          push_ready;
  logic [AW-1:0] push_addr;
  logic          pop_valid;
  logic          pop_ready;
  logic [AW-1:0] pop_addr;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [PW-1:0] lookup_idx;
  logic [PW:0]   count;

  modport master (
    output flush, push_valid, push_addr, pop_ready, lookup_addr,
    input  push_ready, pop_valid, pop_addr, lookup_hit, lookup_idx, count
  );

  modport slave (
    input  flush, push_valid, push_addr, pop_ready, lookup_addr,
    output push_ready, pop_valid, pop_addr, lookup_hit, lookup_idx, count
  );
endinterface

// File: rtl/st_addr_match_queue.sv
// In-order store-address queue with a parallel youngest-match lookup over all valid entries.
// Optional ST_ADDR_MATCH_QUEUE_BYPASS_EN: a firing push is also matchable in its own cycle.

// One slot: valid bit (async reset), unreset address register, and its own equality comparator.
module st_addr_match_queue_entry #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_aL,
  input  logic          set_i,
  input  logic          clr_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [AW-1:0] lookup_addr_i,
  output logic [AW-1:0] addr_o,
  output logic          match_o
);
  logic          vld_q;
  logic [AW-1:0] addr_q;

  // clr wins: it covers flush, which must override a push into this slot
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL)    vld_q <= 1'b0;
    else if (clr_i) vld_q <= 1'b0;
    else if (set_i) vld_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (set_i) addr_q <= wr_addr_i;
  end

  assign addr_o  = addr_q;
  assign match_o = vld_q && (addr_q == lookup_addr_i);
endmodule

module st_addr_match_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  st_addr_match_queue_if.slave    q
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]                head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]              head_idx, tail_idx;
  logic                       empty, full, push_fire, pop_fire;
  logic [DEPTH-1:0]           ent_match;
  logic [DEPTH-1:0][AW-1:0]   ent_addr;
  logic                       hit;
  logic [PW-1:0]              hit_idx, scan_idx;

  assign head_idx  = head_q[PW-1:0];
  assign tail_idx  = tail_q[PW-1:0];
  assign empty     = (head_q == tail_q);
  assign full      = (head_idx == tail_idx) && (head_q[PW] != tail_q[PW]);
  assign push_fire = q.push_valid && !full;
  assign pop_fire  = q.pop_ready && !empty;

  assign q.push_ready = !full;
  assign q.pop_valid  = !empty;
  assign q.pop_addr   = empty ? '0 : ent_addr[head_idx];
  assign q.count      = tail_q - head_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    st_addr_match_queue_entry #(.AW(AW)) u_ent (
      .clk          (clk),
      .rst_aL       (rst_aL),
      .set_i        (push_fire && (tail_idx == PW'(i))),
      .clr_i        (q.flush || (pop_fire && (head_idx == PW'(i)))),
      .wr_addr_i    (q.push_addr),
      .lookup_addr_i(q.lookup_addr),
      .addr_o       (ent_addr[i]),
      .match_o      (ent_match[i])
    );
  end

  // Walk oldest to youngest from head; the last match seen is the youngest.
  // Valid entries always sit in [head, tail), so offset order is age order.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + PW'(k);
      if (ent_match[scan_idx]) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
`ifdef ST_ADDR_MATCH_QUEUE_BYPASS_EN
    if (push_fire && (q.push_addr == q.lookup_addr)) begin
      hit     = 1'b1;
      hit_idx = tail_idx;
    end
`endif
  end

  assign q.lookup_hit = hit;
  assign q.lookup_idx = hit_idx;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (q.flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push_fire) tail_d = tail_q + 1'b1;
      if (pop_fire)  head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: tb/tb_st_addr_match_queue.sv
// Directed bench for st_addr_match_queue: FIFO order, full/empty, youngest-match lookup, flush, async reset.
module tb_st_addr_match_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  int   tests = 0;
  int   fails = 0;

  st_addr_match_queue_if #(.DEPTH(DEPTH), .AW(AW)) qif ();

  st_addr_match_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_aL(rst_aL),
    .q     (qif)
  );

  always #5 clk = ~clk;

`ifdef ST_ADDR_MATCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a);
    qif.push_valid = 1'b1;
    qif.push_addr  = a;
    tick();
    qif.push_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [AW-1:0] exp);
    qif.pop_ready = 1'b1;
    #1;
    chk(tag, qif.pop_addr, exp);
    tick();
    qif.pop_ready = 1'b0;
  endtask

  task automatic do_flush();
    qif.flush = 1'b1;
    tick();
    qif.flush = 1'b0;
  endtask

  task automatic look(input string tag, input logic [AW-1:0] a, input logic h, input logic [2:0] idx);
    qif.lookup_addr = a;
    #1;
    chk({tag, "_hit"}, qif.lookup_hit, h);
    chk({tag, "_idx"}, qif.lookup_idx, idx);
  endtask

  initial begin
    qif.flush = 0; qif.push_valid = 0; qif.push_addr = '0;
    qif.pop_ready = 0; qif.lookup_addr = '0;

    // reset state
    #3;
    chk("rst_count", qif.count, 0);
    chk("rst_push_ready", qif.push_ready, 1);
    chk("rst_pop_valid", qif.pop_valid, 0);
    chk("rst_hit", qif.lookup_hit, 0);
    chk("rst_idx", qif.lookup_idx, 0);
    chk("rst_pop_addr", qif.pop_addr, 0);
    #9 rst_aL = 1'b1;
    tick();

    // basic push and lookup
    push(32'hDEAD_BEEF);
    push(32'h0000_0010);
    #1;
    chk("t1_count", qif.count, 2);
    chk("t1_pop_addr", qif.pop_addr, 32'hDEAD_BEEF);
    look("t1_l10", 32'h10, 1, 1);
    look("t1_ldead", 32'hDEAD_BEEF, 1, 0);
    pop("t1_pop0", 32'hDEAD_BEEF);
    pop("t1_pop1", 32'h10);
    #1 chk("t1_empty", qif.pop_valid, 0);

    // fill to full, drop extra push, drain in order
    for (int i = 0; i < DEPTH; i++) push(32'h100 + i);
    #1;
    chk("t2_push_ready", qif.push_ready, 0);
    chk("t2_count", qif.count, DEPTH);
    push(32'h999);
    #1 chk("t2_drop_count", qif.count, DEPTH);
    for (int i = 0; i < DEPTH; i++) pop($sformatf("t2_pop%0d", i), 32'h100 + i);
    #1;
    chk("t2_pop_valid", qif.pop_valid, 0);
    pop("t2_pop_empty", 32'h0);
    #1 chk("t2_empty_count", qif.count, 0);

    // youngest match
    do_flush();
    push(32'h40); push(32'h80); push(32'h40);
    look("t3_a", 32'h40, 1, 2);
    pop("t3_pop0", 32'h40);
    pop("t3_pop1", 32'h80);
    look("t3_a2", 32'h40, 1, 2);
    look("t3_miss", 32'hFFFF_FFFF, 0, 0);
    pop("t3_pop2", 32'h40);

    // wrap-around with stale slots
    do_flush();
    for (int i = 0; i < DEPTH; i++) push(32'h200 + i);
    for (int i = 0; i < 3; i++) pop($sformatf("t4_pre%0d", i), 32'h200 + i);
    for (int i = 0; i < 3; i++) push(32'h0);
    #1 chk("t4_count", qif.count, DEPTH);
    look("t4_l0", 32'h0, 1, 2);
    for (int i = 3; i < DEPTH; i++) pop($sformatf("t4_pop%0d", i), 32'h200 + i);
    pop("t4_z0", 32'h0);
    look("t4_l0b", 32'h0, 1, 2);
    pop("t4_z1", 32'h0);
    pop("t4_z2", 32'h0);
    look("t4_stale", 32'h0, 0, 0);

    // simultaneous push and pop at count 3
    do_flush();
    push(32'h1); push(32'h2); push(32'h3);
    qif.push_valid = 1; qif.push_addr = 32'h4;
    pop("t5_both", 32'h1);
    qif.push_valid = 0;
    #1 chk("t5_count", qif.count, 3);
    pop("t5_p2", 32'h2);
    pop("t5_p3", 32'h3);
    pop("t5_p4", 32'h4);

    // flush overrides push and pop
    for (int i = 0; i < 4; i++) push(32'h300 + i);
    qif.flush = 1; qif.push_valid = 1; qif.push_addr = 32'h3FF; qif.pop_ready = 1;
    look("t6_preflush", 32'h302, 1, 6);
    tick();
    qif.flush = 0; qif.push_valid = 0; qif.pop_ready = 0;
    #1;
    chk("t6_count", qif.count, 0);
    chk("t6_pop_valid", qif.pop_valid, 0);
    look("t6_post", 32'h302, 0, 0);

    // same-cycle push visibility to lookup
    push(32'hA);
    qif.push_valid = 1; qif.push_addr = 32'h55;
    look("t7_byp", 32'h55, BYP, BYP ? 3'd1 : 3'd0);
    tick();
    qif.push_valid = 0;
    look("t7_next", 32'h55, 1, 1);

    // async reset off a clock edge
    push(32'h77);
    qif.lookup_addr = 32'h77;
    #1 rst_aL = 1'b0;
    #1;
    chk("t8_count", qif.count, 0);
    chk("t8_pop_valid", qif.pop_valid, 0);
    chk("t8_push_ready", qif.push_ready, 1);
    chk("t8_hit", qif.lookup_hit, 0);
    chk("t8_idx", qif.lookup_idx, 0);
    chk("t8_pop_addr", qif.pop_addr, 0);
    @(negedge clk) rst_aL = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
